mul_tile_os: RTL
================

Name: mul_tile_os

Overview:
- Parametrised output-stationary tile multiplier: C[N×N] = A[N×K]·B[K×N] (+E), mod 2^LOGQ, for FrodoKEM-style A·S+E / S·A+E products.
- Internal sequencer, skewed operand injection, an N×N MAC grid, and a row- or column-ordered drain with bias add.
- Sits between the memory controller (operand/bias streams) and the BRAM write-back path.
- Generalises the fixed 4-wide weight-stationary datapath to arbitrary N and K, signed or unsigned packed B operands, and transposed output.

Parameters:
- N, 4, systolic width; the tile is N×N.
- DATA_WIDTH, 16, A element width, accumulator width and output lane width.
- B_WIDTH, 8, packed B element width.
- B_SIGNED, 0, 1 = B elements are two's complement and sign-extended; 0 = zero-extended.
- LOGQ, 16, modulus exponent, LOGQ ≤ DATA_WIDTH; results are masked to LOGQ bits.
- K_MAX, 1344, maximum inner dimension.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches k_len, bias_en, tr_out; honoured only in IDLE.
- clear  in  1  synchronous abort; returns to IDLE and clears the accumulators.
- k_len  in  $clog2(K_MAX+1)  inner-dimension length.
- bias_en  in  1  1 = add the E stream during drain.
- tr_out  in  1  0 = drain rows of C; 1 = drain columns of C.
- busy  out  1  high whenever state ≠ IDLE.
- in_valid  in  1  A column and B row beat present.
- in_ready  out  1  high in LOAD.
- a_data  in  N*DATA_WIDTH  A[i][k] in lane i (lane 0 = LSBs).
- b_data  in  N*B_WIDTH  B[k][j] in lane j.
- e_valid  in  1  bias beat present.
- e_ready  out  1  bias consumed.
- e_data  in  N*DATA_WIDTH  bias for the current drain index.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  N*DATA_WIDTH  drained row/column of C, lane-ordered.
- out_idx  out  $clog2(N)  row (or column) index of out_data.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, rst=1): state IDLE, all accumulators and skew registers 0.
  - Outputs: busy=0, in_ready=0, e_ready=0, out_valid=0, out_data=0, out_idx=0, done=0.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - start with k_len≥1 → LOAD; accumulators cleared in the same edge.
  - start with k_len=0 → DRAIN directly (accumulators cleared).
  - start in any other state is ignored.
- LOAD:
  - A beat transfers when in_valid && in_ready; k_cnt increments per transfer.
  - Lane i of A enters row i after i skew cycles; lane j of B enters column j after j skew cycles.
  - The grid shifts every cycle. Cycles without a transfer inject zeros, so bubbles are harmless.
  - On the transfer with k_cnt = k_len−1 → FLUSH.
- FLUSH: exactly 2N−1 cycles (counter), then → DRAIN.
- PE rule: acc ← (acc + a·ext(b)) mod 2^DATA_WIDTH.
  - ext follows B_SIGNED.
  - The product is truncated to DATA_WIDTH before the add.
- DRAIN: idx runs 0..N−1.
  - tr_out=0: out_data lane j = C[idx][j].
  - tr_out=1: out_data lane i = C[i][idx].
  - Every lane is (acc + (bias_en ? e_lane : 0)) masked to LOGQ bits, upper DATA_WIDTH−LOGQ bits zero.
  - bias_en=1: out_valid = e_valid; e_ready = out_valid && out_ready.
  - bias_en=0: out_valid = 1; e_ready = 0.
  - idx advances on out_valid && out_ready.
  - On the acceptance at idx=N−1 → IDLE, with done=1 for one cycle in the following cycle.
- out_data/out_idx stay stable while out_valid && !out_ready.
- clear has priority over every other event; effective next cycle: IDLE, accumulators 0, done not asserted.
- rst mid-operation: immediate return to the reset values; no partial beat completes.
- k_len > K_MAX: undefined; an assertion in simulation only.
- Total latency with no stalls: start → first out_valid = 1 + k_len + (2N−1) cycles.

Decomposition:
- Package mul_tile_pkg:
  - state enum (IDLE, LOAD, FLUSH, DRAIN);
  - KW = $clog2(K_MAX+1);
  - function b_ext(value, signed flag);
  - function modq(value) for LOGQ masking.
- Sub-module os_pe: one MAC cell with registered a/b pass-through and a clearable accumulator; instantiated N×N via generate.
- Skew lines and the drain mux are in the top.

Test Plan:
- Identity check: N=4, K=4, A=I, B lanes = 1,2,3,4 per row k, bias_en=0, tr_out=0 → C = B, out_idx 0..3, done pulse after beat 3.
- Full-size random product: K=1344, random A and bytes, B_SIGNED=0, bias_en=1, LOGQ=15 → matches the reference model mod 2^15 bit-exact; first out_valid at cycle 1+1344+7.
- Stall stress: random in_valid, out_ready and e_valid gaps → results identical to the no-stall run; out_data stable under backpressure.
- Transposed signed drain: tr_out=1, B_SIGNED=1, b bytes 0xFF (−1), A all 3, K=2 → every lane 0xFFFA (LOGQ=16), columns indexed 0..3.
- Boundary cases:
  - k_len=0 with bias_en=1, e=0x0005 per lane → outputs 0x0005.
  - start pulsed in LOAD → ignored; busy unaffected.
- Abort paths:
  - clear asserted in FLUSH → IDLE next cycle, no done; a following job gives the correct C.
  - rst asserted in DRAIN → all outputs 0 immediately.

Source files
------------

// File: rtl/mul_tile_pkg.sv
// Shared types and helpers for the output-stationary tile multiplier.
// Provides the sequencer state type, the default inner-dimension bound and
// the B-operand extension and modulus-masking helpers used by the datapath.
package mul_tile_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    localparam int K_MAX_DEFAULT = 1344;
    localparam int KW            = $clog2(K_MAX_DEFAULT + 1);

    // Extends a width-bit B element to 64 bits, sign- or zero-filled.
    function automatic logic [63:0] b_ext(input logic [63:0] value, input int width,
                                          input logic is_signed);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        if (is_signed && (((value >> (width - 1)) & 64'd1) != 64'd0))
            return value | ~mask;
        return value & mask;
    endfunction

    // Reduces a value modulo 2^logq by keeping only the low logq bits.
    function automatic logic [63:0] modq(input logic [63:0] value, input int logq);
        if (logq >= 64)
            return value;
        return value & ((64'd1 << logq) - 64'd1);
    endfunction

endpackage

// File: rtl/mul_tile_os_pe.sv
// One multiply-accumulate cell of the output-stationary grid.
// Latency: operands pass through east/south one cycle later; acc updates every cycle.
// Backpressure: none; the cell shifts every cycle and relies on zero-injected bubbles.
// Ports: clk/rst, clr (synchronous wipe of acc and pass-through regs),
//        a_in/a_out (west->east A), b_in/b_out (north->south B), acc (running sum).
module os_pe
    import mul_tile_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int B_WIDTH    = 8,
    parameter bit B_SIGNED   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [B_WIDTH-1:0]    b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [B_WIDTH-1:0]    b_out,
    output logic [DATA_WIDTH-1:0] acc
);

    logic [DATA_WIDTH-1:0] b_x;
    logic [DATA_WIDTH-1:0] prod;

    assign b_x  = DATA_WIDTH'(b_ext(64'(b_in), B_WIDTH, B_SIGNED));
    // Product is evaluated at DATA_WIDTH, so it is already truncated before the add.
    assign prod = a_in * b_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod;
        end
    end

endmodule

// File: rtl/mul_tile_os.sv
// Output-stationary N x N tile multiplier: C = A*B (+E) mod 2^LOGQ, drained by row or column.
// Latency: start to first out_valid is 1 + k_len + (2N-1) cycles without stalls.
// Backpressure: in_valid/in_ready on operands, e_valid/e_ready on bias, out_valid/out_ready on results.
// Ports: start/clear/k_len/bias_en/tr_out control, busy/done status, a_data/b_data operand
//        stream, e_data bias stream, out_data/out_idx drained row or column of C.
module mul_tile_os
    import mul_tile_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int B_WIDTH    = 8,
    parameter bit B_SIGNED   = 1'b0,
    parameter int LOGQ       = 16,
    parameter int K_MAX      = K_MAX_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          clear,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len,
    input  logic                          bias_en,
    input  logic                          tr_out,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N*DATA_WIDTH-1:0]       a_data,
    input  logic [N*B_WIDTH-1:0]          b_data,
    input  logic                          e_valid,
    output logic                          e_ready,
    input  logic [N*DATA_WIDTH-1:0]       e_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N*DATA_WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]          out_idx,
    output logic                          done
);

    localparam int KLW = $clog2(K_MAX + 1);
    localparam int IW  = $clog2(N);
    localparam int FW  = $clog2(2 * N);

    state_t          state;
    logic [KLW-1:0]  k_len_q;
    logic [KLW-1:0]  k_cnt;
    logic            bias_en_q;
    logic            tr_out_q;
    logic [FW-1:0]   flush_cnt;
    logic [IW-1:0]   idx;

    logic fire;
    logic acc_clr;
    logic accept;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == LOAD);
    assign fire      = in_valid && in_ready;
    // Accumulators are wiped both on abort and on every accepted start.
    assign acc_clr   = clear || ((state == IDLE) && start);
    assign out_valid = (state == DRAIN) && (!bias_en_q || e_valid);
    assign accept    = out_valid && out_ready;
    assign e_ready   = bias_en_q && accept;
    assign out_idx   = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k_len_q   <= '0;
            k_cnt     <= '0;
            bias_en_q <= 1'b0;
            tr_out_q  <= 1'b0;
            flush_cnt <= '0;
            idx       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                k_cnt     <= '0;
                flush_cnt <= '0;
                idx       <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        k_len_q   <= k_len;
                        bias_en_q <= bias_en;
                        tr_out_q  <= tr_out;
                        k_cnt     <= '0;
                        flush_cnt <= '0;
                        idx       <= '0;
                        state     <= (k_len == '0) ? DRAIN : LOAD;
                    end
                    LOAD: if (fire) begin
                        if (k_cnt == k_len_q - KLW'(1)) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end else begin
                            k_cnt <= k_cnt + KLW'(1);
                        end
                    end
                    // 2N-1 cycles lets the last skewed beat reach PE(N-1,N-1) and land in acc.
                    FLUSH: begin
                        if (flush_cnt == FW'(2 * N - 2))
                            state <= DRAIN;
                        else
                            flush_cnt <= flush_cnt + FW'(1);
                    end
                    DRAIN: if (accept) begin
                        if (idx == IW'(N - 1)) begin
                            state <= IDLE;
                            idx   <= '0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (state == IDLE) && start)
            assert (k_len <= KLW'(K_MAX));
    end

    // Grid wiring: a_h flows west->east along rows, b_v flows north->south along columns.
    logic [DATA_WIDTH-1:0] a_h   [N][N+1];
    logic [B_WIDTH-1:0]    b_v   [N+1][N];
    logic [DATA_WIDTH-1:0] acc_g [N][N];
    logic [N-1:0]          unused_a_edge;
    logic [N-1:0]          unused_b_edge;

    for (genvar l = 0; l < N; l++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_inj;
        logic [B_WIDTH-1:0]    b_inj;

        // Non-transfer cycles inject zeros, which contribute nothing to any acc.
        assign a_inj = fire ? a_data[l*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_inj = fire ? b_data[l*B_WIDTH +: B_WIDTH] : '0;

        if (l == 0) begin : g_direct
            assign a_h[0][0] = a_inj;
            assign b_v[0][0] = b_inj;
        end else begin : g_skew
            // Lane l is delayed l cycles so A[i][k] and B[k][j] meet at PE(i,j).
            logic [DATA_WIDTH-1:0] a_sr [l];
            logic [B_WIDTH-1:0]    b_sr [l];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < l; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else if (acc_clr) begin
                    for (int d = 0; d < l; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else begin
                    a_sr[0] <= a_inj;
                    b_sr[0] <= b_inj;
                    for (int d = 1; d < l; d++) begin
                        a_sr[d] <= a_sr[d-1];
                        b_sr[d] <= b_sr[d-1];
                    end
                end
            end

            assign a_h[l][0] = a_sr[l-1];
            assign b_v[0][l] = b_sr[l-1];
        end

        assign unused_a_edge[l] = ^a_h[l][N];
        assign unused_b_edge[l] = ^b_v[N][l];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            os_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .B_WIDTH    (B_WIDTH),
                .B_SIGNED   (B_SIGNED)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (acc_clr),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_h[i][j+1]),
                .b_out (b_v[i+1][j]),
                .acc   (acc_g[i][j])
            );
        end
    end

    // Drain mux: select row idx or column idx, add bias, mask to LOGQ bits.
    // Outside DRAIN the bus is forced to zero.
    logic [DATA_WIDTH-1:0] lane_acc;
    logic [DATA_WIDTH-1:0] lane_sum;

    always_comb begin
        out_data = '0;
        lane_acc = '0;
        lane_sum = '0;
        if (state == DRAIN) begin
            for (int l = 0; l < N; l++) begin
                lane_acc = tr_out_q ? acc_g[l][idx] : acc_g[idx][l];
                lane_sum = lane_acc + (bias_en_q ? e_data[l*DATA_WIDTH +: DATA_WIDTH] : '0);
                out_data[l*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(modq(64'(lane_sum), LOGQ));
            end
        end
    end

endmodule
